// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default bit timing.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 104;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with parameterised reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-sampled, LSB first, with framing-error detection and break recovery.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  logic             rx_s;
  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_d;
  logic             valid_d, ferr_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      data      <= data_d;
      valid     <= valid_d;
      frame_err <= ferr_d;
      busy      <= (state_d != ST_IDLE);
    end
  end

  // Next-state: counters stop at their sample point, so cnt never passes CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_LAST) begin
            shreg_d[idx_q] = rx_s;
            cnt_d          = '0;
            idx_d          = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = ST_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rx_s) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_RECOVER;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RECOVER: begin
          if (rx_s) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed + random bench for uart_rx; expected bytes and error counts come from a frame-level model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CPB = CLKS_PER_BIT_DEF;

  logic       clk;
  logic       rstn;
  logic       enable;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  byte unsigned obs_q[$];
  byte unsigned exp_q[$];
  int           obs_ferr  = 0;
  int           exp_ferr  = 0;
  int           both_cnt  = 0;
  int           wide_cnt  = 0;
  bit           prev_valid = 1'b0;
  bit           prev_ferr  = 1'b0;
  logic [7:0]   exp_data;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Event recorder, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) obs_q.push_back(data);
    if (frame_err === 1'b1) obs_ferr++;
    if (valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    if ((valid === 1'b1 && prev_valid) || (frame_err === 1'b1 && prev_ferr)) wide_cnt++;
    prev_valid = (valid === 1'b1);
    prev_ferr  = (frame_err === 1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic drive_bits(input logic [7:0] b, input int nbits);
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < nbits; i++) begin
      rx = b[i];
      cyc(CPB);
    end
  endtask

  // Full 8N1 frame; the model predicts a byte or a framing error from the stop level.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    drive_bits(b, 8);
    rx = stop_ok;
    cyc(CPB);
    if (stop_ok) begin
      exp_q.push_back(b);
      exp_data = b;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic check_events(input string tag);
    check($sformatf("%s.nvalid", tag), 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s.byte%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    check($sformatf("%s.nferr", tag), 32'(obs_ferr), 32'(exp_ferr));
    check($sformatf("%s.both_high", tag), 32'(both_cnt), 32'd0);
    check($sformatf("%s.wide_pulse", tag), 32'(wide_cnt), 32'd0);
    obs_q.delete();
    exp_q.delete();
    obs_ferr = 0;
    exp_ferr = 0;
  endtask

  initial begin
    logic [7:0] rb;
    bit         rok;
    rx       = 1'b1;
    enable   = 1'b1;
    rstn     = 1'b0;
    exp_data = 8'h00;
    cyc(5);
    check("rst.data", 32'(data), 32'h00);
    check("rst.valid", 32'(valid), 32'd0);
    check("rst.frame_err", 32'(frame_err), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    cyc(20);

    send_frame(8'hA5, 1'b1);
    rx = 1'b1;
    cyc(200);
    check_events("a5");
    check("a5.data", 32'(data), 32'(exp_data));

    // Short low glitch: rejected at the start-bit centre check.
    rx = 1'b0;
    cyc(20);
    check("glitch.busy_mid", 32'(busy), 32'd1);
    rx = 1'b1;
    cyc(36);
    check("glitch.busy_end", 32'(busy), 32'd0);
    check_events("glitch");

    // Bad stop followed by a long break.
    send_frame(8'h3C, 1'b0);
    cyc(2000);
    check("break.busy_held", 32'(busy), 32'd1);
    check("break.data_kept", 32'(data), 32'(exp_data));
    rx = 1'b1;
    cyc(10);
    check("break.busy_end", 32'(busy), 32'd0);
    check_events("break");

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    rx = 1'b1;
    cyc(200);
    check_events("b2b");
    check("b2b.data", 32'(data), 32'(exp_data));

    // Reset during bit 4 of 0x81.
    drive_bits(8'h81, 4);
    rx = 1'b0;
    cyc(CPB / 2);
    rstn = 1'b0;
    cyc(3);
    exp_data = 8'h00;
    check("midrst.data", 32'(data), 32'(exp_data));
    check("midrst.busy", 32'(busy), 32'd0);
    rx = 1'b1;
    rstn = 1'b1;
    cyc(200);
    check_events("midrst.idle");
    send_frame(8'h7E, 1'b1);
    rx = 1'b1;
    cyc(200);
    check_events("midrst.7e");
    check("midrst.data_7e", 32'(data), 32'(exp_data));

    // Enable dropped during bit 2 of 0x12.
    drive_bits(8'h12, 2);
    rx = 1'b0;
    cyc(CPB / 2);
    enable = 1'b0;
    cyc(5);
    check("en.busy_low", 32'(busy), 32'd0);
    rx = 1'b1;
    cyc(5);
    enable = 1'b1;
    cyc(200);
    check_events("en.abort");
    check("en.data_kept", 32'(data), 32'(exp_data));
    send_frame(8'h34, 1'b1);
    rx = 1'b1;
    cyc(200);
    check_events("en.34");
    check("en.data_34", 32'(data), 32'(exp_data));

    // Random bytes, occasional bad stop bit, random idle gaps.
    for (int k = 0; k < 8; k++) begin
      rb  = 8'($urandom_range(0, 255));
      rok = ($urandom_range(0, 3) != 0);
      send_frame(rb, rok);
      rx = 1'b1;
      if (rok) cyc($urandom_range(0, 40));
      else     cyc($urandom_range(20, 60));
    end
    cyc(200);
    check_events("rand");
    check("rand.data", 32'(data), 32'(exp_data));
    check("rand.busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
